// File: rtl/serial_addsub_ctrl_pkg.sv
// ============================================================================
// Module      : serial_addsub_pkg
// Description : Shared state encoding and operation codes for the bit-serial
//               add/subtract sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_addsub_ctrl_if.sv
// ============================================================================
// Module      : serial_addsub_ctrl_if
// Description : Start/done request bus between a requester and the serial
//               add/subtract sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, op, opa, opb,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, result, cout, ovf
  );

endinterface

`default_nettype wire

// File: rtl/serial_addsub_ctrl_bit_cell.sv
// ============================================================================
// Module      : addsub_bit_cell
// Description : Single-bit full adder/subtractor built from two half
//               add/sub stages whose carries/borrows are ORed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_bit_cell
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic op,
  output logic r,
  output logic cout
);

  logic w_sub;
  logic w_s1;
  logic w_c1;
  logic w_c2;

  // A half stage generates x&y for add and ~x&y for sub, hence x^op.
  assign w_sub = (op == OP_SUB);
  assign w_s1  = a ^ b;
  assign w_c1  = (a ^ w_sub) & b;
  assign r     = w_s1 ^ cin;
  assign w_c2  = (w_s1 ^ w_sub) & cin;
  assign cout  = w_c1 | w_c2;

endmodule

`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
// ============================================================================
// Module      : serial_addsub_ctrl
// Description : Bit-serial WIDTH-bit adder/subtractor; one bit per clock,
//               LSB first, behind a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_addsub_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op;
  logic               r_carry;
  logic               r_busy;
  logic               r_done;
  logic               r_cout;
  logic               r_ovf;

  logic               w_bit;
  logic               w_carry;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_res_next;

  addsub_bit_cell u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .op   (r_op),
    .r    (w_bit),
    .cout (w_carry)
  );

  // Result bits enter at the MSB so the value is LSB-aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_single
      assign w_res_next = w_bit;
    end else begin : g_res_multi
      assign w_res_next = {w_bit, r_res[WIDTH-1:1]};
    end
  endgenerate

  // On the last bit r_a[0]/r_b[0] are the operand MSBs and w_bit is the result MSB.
  assign w_ovf = (r_op == OP_ADD) ? (~(r_a[0] ^ r_b[0]) & (w_bit ^ r_a[0]))
                                  : ( (r_a[0] ^ r_b[0]) & (w_bit ^ r_a[0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_a     <= bus.opa;
            r_b     <= bus.opb;
            r_op    <= bus.op;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_res_next;
          r_carry <= w_carry;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == C_LAST_BIT) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_cout  <= w_carry;
            r_ovf   <= w_ovf;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_res;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
// ============================================================================
// Module      : tb_serial_addsub_ctrl
// Description : Self-checking bench for serial_addsub_ctrl at WIDTH=8 and
//               WIDTH=1 against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_addsub_ctrl_if #(.WIDTH(8)) if8 ();
  serial_addsub_ctrl_if #(.WIDTH(1)) if1 ();

  serial_addsub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_addsub_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       op;
    int       a;
    int       b;
    int       res;
    bit       co;
    bit       ov;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Signed/unsigned integer arithmetic; returns {cout, ovf, result[7:0]}.
  function automatic logic [9:0] model(input int w, input bit op, input int a, input int b);
    int m, sa, sb, u, s, res;
    bit co, ov;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (op == 1'b0) begin
      u  = a + b;
      s  = sa + sb;
      co = (u >= m);
    end else begin
      u  = a - b;
      s  = sa - sb;
      co = (a < b);
    end
    ov  = (s > m / 2 - 1) || (s < -(m / 2));
    res = ((u % m) + m) % m;
    return {co, ov, 8'(res)};
  endfunction

  task automatic drive(input int w, input bit st, input bit o, input int a, input int b);
    if (w == 8) begin
      if8.start = st; if8.op = o; if8.opa = 8'(a); if8.opb = 8'(b);
    end else begin
      if1.start = st; if1.op = o; if1.opa = 1'(a); if1.opb = 1'(b);
    end
  endtask

  task automatic sample(input int w, output bit bz, output bit dn, output int r,
                        output bit c, output bit v);
    if (w == 8) begin
      bz = if8.busy; dn = if8.done; r = int'(if8.result); c = if8.cout; v = if8.ovf;
    end else begin
      bz = if1.busy; dn = if1.done; r = int'(if1.result); c = if1.cout; v = if1.ovf;
    end
  endtask

  // One complete operation with latency, pulse-width, busy-span and hold checks.
  task automatic run_op(input int w, input bit op, input int a, input int b,
                        input int er, input bit ec, input bit ev);
    bit bz, dn, c, v;
    int r, lat, bcnt, dr;
    bit dc, dv;
    @(negedge clk);
    drive(w, 1'b1, op, a, b);
    @(posedge clk);
    lat = -1; bcnt = 0; dr = 0; dc = 0; dv = 0;
    for (int j = 0; j <= 40 && lat < 0; j++) begin
      @(negedge clk);
      sample(w, bz, dn, r, c, v);
      if (j == 0) begin
        chk("clear_at_accept", {r, c, v}, 0);
        drive(w, 1'b0, ~op, $urandom, $urandom);
      end
      if (bz) bcnt++;
      if (dn) begin lat = j; dr = r; dc = c; dv = v; end
    end
    chk("latency", lat, w);
    if (lat >= 0) begin
      chk("result", dr, er);
      chk("cout", dc, ec);
      chk("ovf", dv, ev);
      chk("busy_cycles", bcnt, w + 1);
      @(negedge clk);
      sample(w, bz, dn, r, c, v);
      chk("done_pulse", dn, 0);
      chk("busy_after", bz, 0);
      chk("hold", {r, c, v}, {er, ec, ev});
    end
  endtask

  vec_t tbl8[$];
  vec_t tbl1[$];

  initial begin
    bit bz, dn, c, v;
    int r, m, a, b;
    logic [9:0] e;
    int dq[$];
    int rq[$];
    bit busy9, busy10;

    checks = 0; errors = 0;
    rst = 1'b1;
    drive(8, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    tbl8.push_back('{0, 'h3C, 'h05, 'h41, 0, 0});
    tbl8.push_back('{0, 'hFF, 'h01, 'h00, 1, 0});
    tbl8.push_back('{0, 'h7F, 'h01, 'h80, 0, 1});
    tbl8.push_back('{1, 'h05, 'h03, 'h02, 0, 0});
    tbl8.push_back('{1, 'h03, 'h05, 'hFE, 1, 0});
    tbl8.push_back('{1, 'h80, 'h01, 'h7F, 0, 1});
    tbl8.push_back('{0, 'h80, 'h80, 'h00, 1, 1});
    tbl8.push_back('{1, 'h7F, 'hFF, 'h80, 1, 1});
    tbl8.push_back('{1, 'h00, 'h00, 'h00, 0, 0});
    tbl1.push_back('{0, 1, 1, 0, 1, 1});
    tbl1.push_back('{1, 0, 1, 1, 1, 1});
    tbl1.push_back('{0, 1, 0, 1, 0, 0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    sample(8, bz, dn, r, c, v);
    chk("reset8", {bz, dn, r, c, v}, 0);
    sample(1, bz, dn, r, c, v);
    chk("reset1", {bz, dn, r, c, v}, 0);
    rst = 1'b0;

    foreach (tbl8[i]) run_op(8, tbl8[i].op, tbl8[i].a, tbl8[i].b, tbl8[i].res, tbl8[i].co, tbl8[i].ov);
    foreach (tbl1[i]) run_op(1, tbl1[i].op, tbl1[i].a, tbl1[i].b, tbl1[i].res, tbl1[i].co, tbl1[i].ov);

    // Second request mid-run is ignored; opa changes after accept have no effect.
    @(negedge clk);
    drive(8, 1, 0, 'h10, 'h20);
    @(posedge clk);
    dq.delete(); rq.delete();
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      sample(8, bz, dn, r, c, v);
      if (dn) begin dq.push_back(j); rq.push_back(r); end
      if (j == 0) drive(8, 0, 0, 'h99, 'h20);
      if (j == 2) drive(8, 1, 1, 'hAA, 'h55);
      if (j == 3) drive(8, 0, 0, 'h00, 'h00);
    end
    chk("ignored_done_count", dq.size(), 1);
    if (dq.size() > 0) begin
      chk("ignored_lat", dq[0], 8);
      chk("ignored_result", rq[0], 'h30);
    end

    // start held high: re-accepted only after the return to IDLE.
    @(negedge clk);
    drive(8, 1, 0, 'h11, 'h22);
    @(posedge clk);
    dq.delete(); rq.delete(); busy9 = 1; busy10 = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      sample(8, bz, dn, r, c, v);
      if (dn) begin dq.push_back(j); rq.push_back(r); end
      if (j == 9) begin busy9 = bz; drive(8, 1, 0, 'h05, 'h06); end
      if (j == 10) begin busy10 = bz; drive(8, 0, 0, 0, 0); end
    end
    chk("held_idle_gap", busy9, 0);
    chk("held_reaccept", busy10, 1);
    chk("held_done_count", dq.size(), 2);
    if (dq.size() == 2) begin
      chk("held_lat1", dq[0], 8);
      chk("held_res1", rq[0], 'h33);
      chk("held_lat2", dq[1], 18);
      chk("held_res2", rq[1], 'h0B);
    end

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    drive(8, 1, 0, 'hFF, 'h00);
    @(posedge clk);
    @(negedge clk);
    drive(8, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    sample(8, bz, dn, r, c, v);
    chk("midrun_reset", {bz, dn, r, c, v}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8, 0, 'h01, 'h01, 'h02, 0, 0);

    // Randomised operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      m = (k < 32) ? 256 : 2;
      a = $urandom_range(0, m - 1);
      b = $urandom_range(0, m - 1);
      c = 1'($urandom);
      e = model((k < 32) ? 8 : 1, c, a, b);
      run_op((k < 32) ? 8 : 1, c, a, b, int'(e[7:0]), e[9], e[8]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial N-bit adder/subtractor sequencer. One add/sub bit cell is reused every clock: one operand bit pair per cycle, LSB first.
- Carry/borrow is held in a flop between cycles.
- Sits beside the combinational half add/sub datapath. Gives area-constrained paths multi-bit add/sub from a single bit cell, behind a start/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
- opa  input  WIDTH  operand a; sampled with start
- opb  input  WIDTH  operand b; sampled with start
- busy  output  1  high while not IDLE
- done  output  1  one-cycle pulse; results valid
- result  output  WIDTH  sum or difference
- cout  output  1  carry-out (add) or borrow-out (sub)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0.
  - Internal operand shift registers, carry flop and counter cleared.
  - No partial result survives.
- States and transitions:
  - IDLE -> RUN on start=1: latch opa, opb, op; carry flop=0; counter=0.
  - RUN: each edge processes bit[counter] and increments counter. After the edge that processes bit WIDTH-1 -> DONE.
  - DONE: done=1 for exactly one cycle, then unconditionally -> IDLE.
- Per-bit arithmetic (bit cell: two half stages plus OR of stage carries/borrows):
  - add: s = a^b^c; c' = (a&b) | (c&(a^b)).
  - sub: d = a^b^w; w' = (~a&b) | (~(a^b)&w).
  - Result bits shift in from the MSB end. After WIDTH bits, result holds the full value, LSB aligned.
- Latency:
  - start sampled at edge E0; bits processed at edges E1..E_WIDTH.
  - done is high in the cycle following E_WIDTH.
  - Start to done = WIDTH cycles; busy spans WIDTH+1 cycles.
  - Throughput: one operation per WIDTH+2 cycles max.
- cout = final carry flop (add) or final borrow flop (sub); updated at E_WIDTH.
- ovf from latched operand MSBs and result MSB, updated at E_WIDTH:
  - add: ~(a[msb]^b[msb]) & (r[msb]^a[msb]).
  - sub: (a[msb]^b[msb]) & (r[msb]^a[msb]).
- result, cout and ovf hold their values after done until the next accepted start. They are cleared at the start-accept edge and are not valid while busy.
- start is ignored in RUN and DONE; no queuing. start held high continuously restarts immediately on return to IDLE.
- opa, opb and op may change freely after the accept edge; latched copies are used.
- WIDTH=1: RUN lasts one cycle; done one cycle later.

Decomposition:
- Package serial_addsub_pkg:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding.
  - Constants OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module addsub_bit_cell (combinational): inputs a, b, cin, op; outputs r, cout. Built from two half add/sub stages plus OR.
- Top level holds FSM, counter, shift registers and flag logic.

Test Plan:
- WIDTH=8, op=0, 0x3C+0x05 -> result=0x41, cout=0, ovf=0; done exactly 8 cycles after start edge, single-cycle pulse; busy high 9 cycles.
- 0xFF+0x01 add -> 0x00, cout=1, ovf=0. 0x7F+0x01 add -> 0x80, cout=0, ovf=1.
- op=1: 0x05-0x03 -> 0x02, cout=0. 0x03-0x05 -> 0xFE, cout=1, ovf=0. 0x80-0x01 -> 0x7F, cout=1? no: 0x80-0x01 gives borrow 0, ovf=1.
- Start 0x10+0x20, then pulse start with 0xAA/0x55 at cycle 3 and change opa mid-run -> result=0x30, second request ignored; held start afterwards accepted only after IDLE.
- Assert rst at bit 3 of a run -> all outputs 0 immediately, busy=0. Next start 0x01+0x01 completes with 0x02 after 8 cycles.
- WIDTH=1 build: 1+1 add -> result=0, cout=1, ovf=1 (signed -1 + -1 = -2 does not fit in 1 bit); done 1 cycle after start.
